// File: rtl/std_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : std_ctrl_pkg
//  Brief    : Shared types and helpers for the std_* control sequencers.
//  Revision : 1.0
// ============================================================================
package std_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/std_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : std_wait_timer
//  Brief    : Saturating wait counter; expired flags the LIMIT-th idle cycle.
//  Revision : 1.0
// ============================================================================
module std_wait_timer
    import std_ctrl_pkg::*;
#(
    parameter int LIMIT = 4
)(
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int              c_CNT_W = clog2_min1(LIMIT);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(LIMIT - 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_LAST)) begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    // Fires in the cycle whose increment would bring the count to LIMIT.
    assign o_expired = i_enable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/std_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : std_seq_ctrl
//  Brief    : go/done initiator that runs NUM_STEPS children in order,
//             iter_count times, then pulses done for one cycle.
//  Revision : 1.0
// ============================================================================
module std_seq_ctrl
    import std_ctrl_pkg::*;
#(
    parameter int NUM_STEPS      = 2,
    parameter int ITER_W         = 8,
    parameter int TIMEOUT_CYCLES = 0
)(
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                go,
    input  logic [ITER_W-1:0]                   iter_count,
    output logic [NUM_STEPS-1:0]                child_go,
    input  logic [NUM_STEPS-1:0]                child_done,
    output logic                                done,
    output logic                                busy,
    output logic [clog2_min1(NUM_STEPS)-1:0]    cur_step,
    output logic [ITER_W-1:0]                   cur_iter,
    output logic                                timeout_err
);

    localparam int                  c_STEP_W    = clog2_min1(NUM_STEPS);
    localparam logic [c_STEP_W-1:0] c_LAST_STEP = c_STEP_W'(NUM_STEPS - 1);

    ctrl_state_t         r_state;
    logic [c_STEP_W-1:0] r_cur_step;
    logic [ITER_W-1:0]   r_cur_iter;
    logic [ITER_W-1:0]   r_iter_target;
    logic                r_timeout_err;
    logic                r_done;
    logic                r_busy;

    logic                w_step_done;
    logic                w_expired;
    logic [ITER_W-1:0]   w_iter_next;

    // Only the active child's done matters; stale or foreign done is ignored.
    assign w_step_done = (r_state == RUN) && child_done[r_cur_step];
    assign w_iter_next = r_cur_iter + ITER_W'(1);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            logic w_timer_clear;
            logic w_timer_en;

            assign w_timer_clear = (r_state != RUN) || w_step_done;
            assign w_timer_en    = (r_state == RUN) && !w_step_done;

            std_wait_timer #(
                .LIMIT (TIMEOUT_CYCLES)
            ) u_wait_timer (
                .clk       (clk),
                .reset     (reset),
                .i_clear   (w_timer_clear),
                .i_enable  (w_timer_en),
                .o_expired (w_expired)
            );
        end else begin : g_no_timeout
            assign w_expired = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cur_step    <= '0;
            r_cur_iter    <= '0;
            r_iter_target <= '0;
            r_timeout_err <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (go) begin
                        r_timeout_err <= 1'b0;
                        r_cur_step    <= '0;
                        r_cur_iter    <= '0;
                        r_busy        <= 1'b1;
                        if (iter_count != '0) begin
                            r_iter_target <= iter_count;
                            r_state       <= RUN;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_step_done) begin
                        if (r_cur_step == c_LAST_STEP) begin
                            r_cur_step <= '0;
                            r_cur_iter <= w_iter_next;
                            if (w_iter_next == r_iter_target) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_cur_step <= r_cur_step + c_STEP_W'(1);
                        end
                    end else if (w_expired) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= DONE;
                        r_done        <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        child_go = '0;
        if (r_state == RUN) begin
            child_go[r_cur_step] = 1'b1;
        end
    end

    assign done        = r_done;
    assign busy        = r_busy;
    assign cur_step    = r_cur_step;
    assign cur_iter    = r_cur_iter;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_std_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_std_seq_ctrl
//  Brief    : Scoreboard bench for std_seq_ctrl with latency-programmable children.
//  Revision : 1.0
// ============================================================================
module tb_std_seq_ctrl;

    localparam int c_TO = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       go = 1'b0;
    logic [7:0] iter_count = '0;
    logic [1:0] child_go;
    logic [1:0] child_done;
    logic       done;
    logic       busy;
    logic [0:0] cur_step;
    logic [7:0] cur_iter;
    logic       timeout_err;

    std_seq_ctrl #(
        .NUM_STEPS      (2),
        .ITER_W         (8),
        .TIMEOUT_CYCLES (c_TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .go          (go),
        .iter_count  (iter_count),
        .child_go    (child_go),
        .child_done  (child_done),
        .done        (done),
        .busy        (busy),
        .cur_step    (cur_step),
        .cur_iter    (cur_iter),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Child i answers after lat[i] cycles of held go (lat=1 behaves like std_reg).
    int         lat  [2];
    int         hold [2];
    logic [1:0] spur = '0;

    initial begin
        lat[0] = 0; lat[1] = 0; hold[0] = 0; hold[1] = 0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) hold[i] <= child_go[i] ? hold[i] + 1 : 0;
    end

    always_comb begin
        child_done = '0;
        for (int i = 0; i < 2; i++)
            child_done[i] = child_go[i] ? (hold[i] == lat[i]) : spur[i];
    end

    typedef struct {
        int done_cyc;
        int iters;
        bit terr;
        bit nz;
    } run_t;

    run_t       run_q[$];
    logic [1:0] trace_q[$];
    int         rst_q[$];

    int checks = 0;
    int errors = 0;
    int n_accept = 0;
    int n_done = 0;
    bit mon_en = 1'b0;
    bit exp_sticky = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_q.size() > 0 && rst_q[0] == cyc) begin
                void'(rst_q.pop_front());
                chk("rst_busy", busy, 0);
                chk("rst_child_go", child_go, 0);
                chk("rst_cur_iter", cur_iter, 0);
                chk("rst_done", done, 0);
                chk("rst_timeout_err", timeout_err, 0);
                exp_sticky = 1'b0;
            end else begin
                if (busy === 1'b1) begin
                    if (trace_q.size() == 0) begin
                        chk("busy_unexpected", busy, 0);
                    end else begin
                        logic [1:0] eg;
                        eg = trace_q.pop_front();
                        chk("child_go", child_go, eg);
                        if (eg != 2'b00) chk("cur_step", cur_step, eg[1]);
                        if (done !== 1'b1) chk("run_timeout_err", timeout_err, 0);
                    end
                end else begin
                    chk("idle_child_go", child_go, 0);
                    chk("idle_timeout_err", timeout_err, exp_sticky);
                end

                if (done === 1'b1) begin
                    if (run_q.size() == 0) begin
                        chk("unexpected_done", done, 0);
                    end else begin
                        run_t r;
                        r = run_q.pop_front();
                        chk("done_cycle", cyc, r.done_cyc);
                        chk("done_busy", busy, 1);
                        if (r.nz) chk("done_cur_iter", cur_iter, r.iters);
                        chk("done_timeout_err", timeout_err, r.terr);
                        exp_sticky = r.terr;
                        n_done++;
                    end
                end else if (run_q.size() > 0 && cyc > run_q[0].done_cyc) begin
                    chk("done_missing", done, 1);
                    void'(run_q.pop_front());
                end
            end
        end
    end

    function automatic int rand_lat();
        int v;
        v = $urandom_range(0, 11);
        if (v < 8)   return v % 4;
        if (v < 10)  return 3;
        if (v == 10) return 4;
        return 200;
    endfunction

    task automatic idle(input int g);
        repeat (g) begin
            @(posedge clk); #2;
            go   = 1'b0;
            spur = 2'($urandom);
        end
    endtask

    // Expected trace: every step holds its go for latency+1 cycles, or for
    // the timeout length if the child is too slow, followed by the DONE cycle.
    task automatic do_run(input int n, input int l0, input int l1,
                          input bit pulses, input int abort_at);
        run_t r;
        int   lats[2];
        int   total;
        int   d;
        bit   stop;
        lats[0] = l0; lats[1] = l1;
        total = 0; stop = 1'b0;
        r.terr = 1'b0; r.iters = 0;
        @(posedge clk); #2;
        for (int it = 0; it < n && !stop; it++) begin
            for (int s = 0; s < 2 && !stop; s++) begin
                int dur;
                if (lats[s] >= c_TO) begin
                    dur = c_TO; stop = 1'b1; r.terr = 1'b1;
                end else begin
                    dur = lats[s] + 1;
                end
                repeat (dur) trace_q.push_back(2'(1 << s));
                total += dur;
            end
            if (!stop) r.iters++;
        end
        trace_q.push_back(2'b00);
        d = total + 1;
        r.done_cyc = cyc + d;
        r.nz = (n != 0);
        run_q.push_back(r);
        lat[0] = l0; lat[1] = l1;
        go = 1'b1;
        iter_count = 8'(n);
        spur = 2'($urandom);
        for (int k = 1; k <= d; k++) begin
            @(posedge clk); #2;
            spur       = 2'($urandom);
            iter_count = 8'($urandom);
            go         = pulses && ($urandom_range(0, 3) == 0);
            if (k == abort_at) begin
                reset = 1'b1;
                go    = 1'b0;
            end else if (abort_at != 0 && k == abort_at + 1) begin
                reset = 1'b0;
                run_q.delete();
                trace_q.delete();
                rst_q.push_back(cyc);
                return;
            end
        end
        n_accept++;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        rst_q.push_back(cyc);
        mon_en = 1'b1;

        do_run(1, 1, 1, 1'b0, 0);
        idle(1);
        do_run(3, 0, 0, 1'b0, 0);
        idle(2);
        do_run(0, 1, 1, 1'b1, 0);
        idle(1);
        do_run(2, 1, 200, 1'b0, 0);
        idle(2);
        do_run(1, 1, 1, 1'b0, 0);
        idle(1);
        do_run(3, 1, 1, 1'b0, 7);
        do_run(2, 2, 0, 1'b1, 0);
        do_run(255, 0, 0, 1'b0, 0);
        for (int i = 0; i < 60; i++) begin
            idle($urandom_range(0, 2));
            do_run($urandom_range(0, 4), rand_lat(), rand_lat(), 1'b1, 0);
        end
        idle(6);
        mon_en = 1'b0;

        chk("pending_runs", run_q.size(), 0);
        chk("pending_trace", trace_q.size(), 0);
        chk("done_count", n_done, n_accept);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit (errors=%0d)", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/std_seq_ctrl.md
Name: std_seq_ctrl

Overview:
- Control-side initiator for the go/done handshake used by the std_* datapath primitives; std_reg, for example, takes go on write_en and answers with a registered done.
- On its own go, drives child go lines one at a time, in step order, for NUM_STEPS children and repeats the sequence iter_count times.
- Reports completion upward with a one-cycle done, which makes it nestable under another std_seq_ctrl.
- Sits between a top-level driver and datapath instances on the fabric; replaces hand-written per-design FSMs.

Parameters:
- NUM_STEPS, 2, number of child components sequenced per iteration (>=1).
- ITER_W, 8, width of the iteration count input.
- TIMEOUT_CYCLES, 0, maximum cycles a step may wait for child done; 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- go  input  1  start request from the parent; sampled only in IDLE.
- iter_count  input  ITER_W  number of sequence repetitions; latched when go is accepted.
- child_go  output  NUM_STEPS  one-hot go to the children.
- child_done  input  NUM_STEPS  done from the children; only bit cur_step is observed.
- done  output  1  one-cycle completion pulse.
- busy  output  1  high in RUN and DONE.
- cur_step  output  $clog2(NUM_STEPS) (min 1)  active step index.
- cur_iter  output  ITER_W  completed iterations in the current run.
- timeout_err  output  1  sticky; set when a step times out.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset, synchronous and active-high:
  - state=IDLE, cur_step=0, cur_iter=0, timeout_err=0, wait counter=0.
  - child_go=0, done=0, busy=0.
  - Reset asserted mid-RUN forces child_go to 0 from the following cycle; no done is issued.
- IDLE:
  - go=1 and iter_count>0 → latch iter_count, clear timeout_err, cur_step=0, cur_iter=0, next state RUN.
  - go=1 and iter_count==0 → clear timeout_err, next state DONE; no child_go is ever asserted.
  - go=0 → stay in IDLE.
- RUN:
  - child_go[cur_step]=1; all other bits are 0. child_go is decoded combinationally from state and cur_step.
  - go is ignored while in RUN and DONE.
  - child_done[cur_step]=1 at a clock edge → advance, and clear the wait counter.
    - cur_step<NUM_STEPS-1: cur_step+1.
    - Otherwise cur_step=0 and cur_iter+1. If cur_iter+1 equals the latched count, next state is DONE.
  - child_done bits at indices other than cur_step are ignored, including stale done from the previous child.
- Timing:
  - go accepted at edge e → child_go[0] high in the cycle after e.
  - A child with 1-cycle done latency (std_reg) holds child_go for 2 cycles: the go cycle and the done cycle.
  - Overhead per step is 0 extra cycles; a step advances on the edge that samples done.
- Timeout (TIMEOUT_CYCLES>0):
  - The wait counter increments each RUN cycle in which child_done[cur_step]=0.
  - If the counter reaches TIMEOUT_CYCLES while done is still low → timeout_err=1, next state DONE.
  - child_go drops from the following cycle.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - Parent contract: go is low in the cycle after done. If go is still high in IDLE, a new run starts.
- Width rules:
  - cur_iter compares against the latched count at full ITER_W width.
  - Maximum run length is 2^ITER_W-1 iterations; no wrap occurs.
- child_go is never multi-hot, and is never high outside RUN.

Decomposition:
- std_ctrl_pkg holds:
  - Enum typedef ctrl_state_t {IDLE, RUN, DONE}.
  - Function clog2_min1 for index widths.
- Sub-module: std_wait_timer, holding the wait counter with clear/enable/expired. It is instantiated only when TIMEOUT_CYCLES>0 (generate); otherwise expired is tied 0.

Test Plan:
- NUM_STEPS=2, iter_count=1, two std_reg children (write_en=child_go) → child_go=01 in cycles 1–2, 10 in cycles 3–4; done in cycle 5; each reg written with its input.
- iter_count=3, children with done latency 0 (done=go) → steps alternate each cycle: 01,10,01,10,01,10; done in cycle 7; cur_iter=3 in the DONE cycle.
- iter_count=0 with go → done in cycle 1, child_go stays 0 throughout, busy high only in cycle 1.
- TIMEOUT_CYCLES=4, child 1 never answers → child_go[1] high for 4 cycles, then timeout_err=1 with a done pulse. The next accepted go clears timeout_err.
- Assert reset during step 1 of iteration 2 → child_go=0, busy=0, cur_iter=0 in the cycle after reset; no done. A fresh go then runs a full correct sequence.
- Spurious child_done[1] while on step 0, plus go pulsed during RUN → step does not advance, no restart, and the done count equals the number of accepted gos.
